// File: rtl/bmm150_pkg.sv
// rtl/bmm150_pkg.sv - BMM150 register map, sequencer states and overflow codes
package bmm150_pkg;

    localparam logic [6:0] REG_CHIP_ID    = 7'h40;
    localparam logic [6:0] REG_DATA_X_LSB = 7'h42;
    localparam logic [6:0] REG_PWR        = 7'h4B;
    localparam logic [6:0] REG_OPMODE     = 7'h4C;
    localparam logic [6:0] REG_REPXY      = 7'h51;
    localparam logic [6:0] REG_REPZ       = 7'h52;

    // Raw bit patterns the sensor reports on axis overflow (-4096 / -16384)
    localparam logic [12:0] XY_OVF_CODE = 13'h1000;
    localparam logic [14:0] Z_OVF_CODE  = 15'h4000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PWR_ON,
        S_PWR_WAIT,
        S_ID_RD,
        S_ID_CHK,
        S_WR_REPXY,
        S_WR_REPZ,
        S_WR_OPM,
        S_SMP_WAIT,
        S_BURST,
        S_PARSE,
        S_ERR
    } state_t;

endpackage

// File: rtl/bmm150_delay_timer.sv
// rtl/bmm150_delay_timer.sv - loadable down-counter, expired while the count is zero
module bmm150_delay_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_expired
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/bmm150_ctrl.sv
// rtl/bmm150_ctrl.sv - BMM150 power-up/config sequencer and periodic burst-read parser
module bmm150_ctrl #(
    parameter int         CLK_HZ     = 50_000_000,
    parameter int         POWERUP_US = 3000,
    parameter int         SAMPLE_HZ  = 10,
    parameter logic [7:0] CHIP_ID    = 8'h32,
    parameter logic [2:0] ODR_CODE   = 3'b000,
    parameter logic [7:0] REPXY      = 8'h04,
    parameter logic [7:0] REPZ       = 8'h07
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    output logic               spi_enable,
    output logic               spi_start,
    output logic               spi_burst,
    output logic               spi_rw,
    output logic [6:0]         spi_addr,
    output logic [7:0]         spi_wdata,
    input  logic [7:0]         spi_rdata,
    input  logic [63:0]        spi_bdata,
    input  logic               spi_busy,
    input  logic               spi_done,
    output logic               init_done,
    output logic               id_err,
    output logic [7:0]         chip_id,
    output logic signed [12:0] mag_x,
    output logic signed [12:0] mag_y,
    output logic signed [14:0] mag_z,
    output logic [13:0]        rhall,
    output logic               ovf,
    output logic               drdy,
    output logic               data_valid
);
    import bmm150_pkg::*;

    localparam int N_PWR = (CLK_HZ / 1_000_000) * POWERUP_US;
    localparam int N_SMP = CLK_HZ / SAMPLE_HZ;
    localparam int N_MAX = (N_PWR > N_SMP) ? N_PWR : N_SMP;
    localparam int TW    = (N_MAX > 1) ? $clog2(N_MAX) : 1;
    localparam logic [TW-1:0] PWR_LOAD = TW'(N_PWR - 1);
    localparam logic [TW-1:0] SMP_LOAD = TW'(N_SMP - 1);

    state_t        r_state, w_state_nxt;
    logic          r_issued, r_spi_enable, r_spi_start, r_spi_burst, r_spi_rw;
    logic [6:0]    r_spi_addr;
    logic [7:0]    r_spi_wdata, r_chip_id;
    logic [63:0]   r_bdata;
    logic          r_init_done, r_id_err, r_ovf, r_drdy, r_data_valid;
    logic [12:0]   r_mag_x, r_mag_y;
    logic [14:0]   r_mag_z;
    logic [13:0]   r_rhall;

    logic          w_is_op, w_op_rw, w_op_burst, w_issue, w_op_done;
    logic [6:0]    w_op_addr;
    logic [7:0]    w_op_wdata;
    logic          w_tmr_load, w_tmr_exp;
    logic [TW-1:0] w_tmr_val;
    logic [12:0]   w_x, w_y;
    logic [14:0]   w_z;
    logic [13:0]   w_rh;

    bmm150_delay_timer #(.W(TW)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_tmr_load),
        .i_val     (w_tmr_val),
        .o_expired (w_tmr_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_is_op    = 1'b1;
        w_op_rw    = 1'b0;
        w_op_burst = 1'b0;
        w_op_addr  = REG_PWR;
        w_op_wdata = 8'h00;
        case (r_state)
            S_PWR_ON:   w_op_wdata = 8'h01;
            S_ID_RD:    begin w_op_rw = 1'b1; w_op_addr = REG_CHIP_ID; end
            S_WR_REPXY: begin w_op_addr = REG_REPXY; w_op_wdata = REPXY; end
            S_WR_REPZ:  begin w_op_addr = REG_REPZ; w_op_wdata = REPZ; end
            S_WR_OPM:   begin w_op_addr = REG_OPMODE; w_op_wdata = {2'b00, ODR_CODE, 3'b000}; end
            S_BURST:    begin w_op_rw = 1'b1; w_op_burst = 1'b1; w_op_addr = REG_DATA_X_LSB; end
            default:    w_is_op = 1'b0;
        endcase

        // Issue only into a fully idle master so a lingering done is never mistaken for ours
        w_issue   = enable && w_is_op && !r_issued && !spi_busy && !spi_done;
        w_op_done = enable && w_is_op && r_issued && spi_done;

        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:     w_state_nxt = S_PWR_ON;
                S_PWR_ON:   if (w_op_done) w_state_nxt = S_PWR_WAIT;
                S_PWR_WAIT: if (w_tmr_exp) w_state_nxt = S_ID_RD;
                S_ID_RD:    if (w_op_done) w_state_nxt = S_ID_CHK;
                S_ID_CHK:   w_state_nxt = (r_chip_id == CHIP_ID) ? S_WR_REPXY : S_ERR;
                S_WR_REPXY: if (w_op_done) w_state_nxt = S_WR_REPZ;
                S_WR_REPZ:  if (w_op_done) w_state_nxt = S_WR_OPM;
                S_WR_OPM:   if (w_op_done) w_state_nxt = S_SMP_WAIT;
                S_SMP_WAIT: if (w_tmr_exp) w_state_nxt = S_BURST;
                S_BURST:    if (w_op_done) w_state_nxt = S_PARSE;
                S_PARSE:    w_state_nxt = S_SMP_WAIT;
                S_ERR:      if (w_tmr_exp) w_state_nxt = S_PWR_ON;
                default:    w_state_nxt = S_IDLE;
            endcase
        end

        w_tmr_load = (w_state_nxt != r_state) &&
                     (w_state_nxt == S_PWR_WAIT || w_state_nxt == S_SMP_WAIT || w_state_nxt == S_ERR);
        w_tmr_val  = (w_state_nxt == S_PWR_WAIT) ? PWR_LOAD : SMP_LOAD;
    end

    // Byte b(n) sits at bdata[63-8n -: 8]
    assign w_x  = {r_bdata[55:48], r_bdata[63:59]};
    assign w_y  = {r_bdata[39:32], r_bdata[47:43]};
    assign w_z  = {r_bdata[23:16], r_bdata[31:25]};
    assign w_rh = {r_bdata[7:0],   r_bdata[15:10]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issued     <= 1'b0;
            r_spi_enable <= 1'b0;
            r_spi_start  <= 1'b0;
            r_spi_burst  <= 1'b0;
            r_spi_rw     <= 1'b1;
            r_spi_addr   <= '0;
            r_spi_wdata  <= '0;
            r_bdata      <= '0;
            r_chip_id    <= '0;
            r_init_done  <= 1'b0;
            r_id_err     <= 1'b0;
            r_mag_x      <= '0;
            r_mag_y      <= '0;
            r_mag_z      <= '0;
            r_rhall      <= '0;
            r_ovf        <= 1'b0;
            r_drdy       <= 1'b0;
            r_data_valid <= 1'b0;
        end else begin
            r_spi_enable <= enable;
            r_spi_start  <= w_issue;
            r_data_valid <= 1'b0;
            if (w_issue) begin
                r_issued    <= 1'b1;
                r_spi_addr  <= w_op_addr;
                r_spi_rw    <= w_op_rw;
                r_spi_wdata <= w_op_wdata;
                r_spi_burst <= w_op_burst;
            end
            if (w_op_done || !enable) begin
                r_issued <= 1'b0;
            end
            if (!enable) begin
                r_init_done <= 1'b0;
            end
            if (w_op_done && r_state == S_ID_RD) begin
                r_chip_id <= spi_rdata;
            end
            if (w_op_done && r_state == S_BURST) begin
                r_bdata <= spi_bdata;
            end
            if (r_state == S_ID_CHK && w_state_nxt == S_ERR) begin
                r_id_err <= 1'b1;
            end
            if (w_op_done && r_state == S_WR_OPM) begin
                r_id_err    <= 1'b0;
                r_init_done <= 1'b1;
            end
            if (enable && r_state == S_PARSE) begin
                r_mag_x      <= w_x;
                r_mag_y      <= w_y;
                r_mag_z      <= w_z;
                r_rhall      <= w_rh;
                r_drdy       <= r_bdata[8];
                r_ovf        <= (w_x == XY_OVF_CODE) || (w_y == XY_OVF_CODE) || (w_z == Z_OVF_CODE);
                r_data_valid <= 1'b1;
            end
        end
    end

    assign spi_enable = r_spi_enable;
    assign spi_start  = r_spi_start;
    assign spi_burst  = r_spi_burst;
    assign spi_rw     = r_spi_rw;
    assign spi_addr   = r_spi_addr;
    assign spi_wdata  = r_spi_wdata;
    assign init_done  = r_init_done;
    assign id_err     = r_id_err;
    assign chip_id    = r_chip_id;
    assign mag_x      = r_mag_x;
    assign mag_y      = r_mag_y;
    assign mag_z      = r_mag_z;
    assign rhall      = r_rhall;
    assign ovf        = r_ovf;
    assign drdy       = r_drdy;
    assign data_valid = r_data_valid;

endmodule

// File: tb/tb_bmm150_ctrl.sv
// tb/tb_bmm150_ctrl.sv - scoreboard bench for bmm150_ctrl with a behavioural SPI master
module tb_bmm150_ctrl;

    typedef struct {
        logic       rw;
        logic       burst;
        logic [6:0] addr;
        logic [7:0] wdata;
    } op_t;

    typedef struct {
        logic [12:0] x;
        logic [12:0] y;
        logic [14:0] z;
        logic [13:0] rh;
        logic        ovf;
        logic        drdy;
    } smp_t;

    logic               clk, rst_n, enable;
    logic               spi_enable, spi_start, spi_burst, spi_rw;
    logic [6:0]         spi_addr;
    logic [7:0]         spi_wdata, spi_rdata;
    logic [63:0]        spi_bdata;
    logic               spi_busy, spi_done;
    logic               init_done, id_err, ovf, drdy, data_valid;
    logic [7:0]         chip_id;
    logic signed [12:0] mag_x, mag_y;
    logic signed [14:0] mag_z;
    logic [13:0]        rhall;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_dv = 0;
    int n_init = 0;
    int n_starts = 0;
    int extra_busy = 0;
    int act_cnt = 0;
    logic act = 1'b0;
    int post = 0;
    op_t cur;
    logic [6:0] last_done_addr = 7'h00;
    int t_last_done = 0;
    logic prev_dv = 1'b0;
    logic prev_init = 1'b0;

    op_t         opq[$];
    logic [63:0] bq[$];
    logic [7:0]  idq[$];
    smp_t        expq[$];
    smp_t        obsq[$];

    bmm150_ctrl #(
        .CLK_HZ     (1_000_000),
        .POWERUP_US (20),
        .SAMPLE_HZ  (10_000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .spi_enable (spi_enable),
        .spi_start  (spi_start),
        .spi_burst  (spi_burst),
        .spi_rw     (spi_rw),
        .spi_addr   (spi_addr),
        .spi_wdata  (spi_wdata),
        .spi_rdata  (spi_rdata),
        .spi_bdata  (spi_bdata),
        .spi_busy   (spi_busy),
        .spi_done   (spi_done),
        .init_done  (init_done),
        .id_err     (id_err),
        .chip_id    (chip_id),
        .mag_x      (mag_x),
        .mag_y      (mag_y),
        .mag_z      (mag_z),
        .rhall      (rhall),
        .ovf        (ovf),
        .drdy       (drdy),
        .data_valid (data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic smp_t parse(input logic [63:0] d);
        logic [7:0] b[8];
        smp_t m;
        for (int i = 0; i < 8; i++) b[i] = d[63-8*i -: 8];
        m.x    = {b[1], b[0][7:3]};
        m.y    = {b[3], b[2][7:3]};
        m.z    = {b[5], b[4][7:1]};
        m.rh   = {b[7], b[6][7:2]};
        m.drdy = b[6][0];
        m.ovf  = (m.x == 13'h1000) || (m.y == 13'h1000) || (m.z == 15'h4000);
        return m;
    endfunction

    function automatic op_t mk(input logic rw, input logic burst, input logic [6:0] a, input logic [7:0] w);
        op_t o;
        o.rw = rw; o.burst = burst; o.addr = a; o.wdata = w;
        return o;
    endfunction

    task automatic push_cfg();
        opq.push_back(mk(1'b0, 1'b0, 7'h51, 8'h04));
        opq.push_back(mk(1'b0, 1'b0, 7'h52, 8'h07));
        opq.push_back(mk(1'b0, 1'b0, 7'h4C, 8'h00));
    endtask

    // Behavioural SPI master: 3-cycle transactions, optional busy tail after done
    always @(negedge clk) begin
        if (!rst_n || !spi_enable) begin
            spi_busy = 1'b0; spi_done = 1'b0; act = 1'b0; post = 0;
        end else begin
            spi_done = 1'b0;
            if (post > 0) begin
                post--;
                if (post == 0) spi_busy = 1'b0;
            end
            if (spi_start) begin
                op_t e;
                n_starts++;
                chk("start_while_busy", spi_busy, 1'b0);
                cur = mk(spi_rw, spi_burst, spi_addr, spi_wdata);
                if (opq.size() == 0) begin
                    chk("unexpected_start_addr", spi_addr, 7'h7F);
                end else begin
                    e = opq.pop_front();
                    chk("op_addr", spi_addr, e.addr);
                    chk("op_rw", spi_rw, e.rw);
                    chk("op_burst", spi_burst, e.burst);
                    if (!e.rw) chk("op_wdata", spi_wdata, e.wdata);
                end
                if (spi_addr == 7'h40 && last_done_addr == 7'h4B)
                    chk("powerup_gap_ge20", (cyc - t_last_done) >= 20, 1'b1);
                if (spi_addr == 7'h4B && last_done_addr == 7'h40)
                    chk("retry_gap_ge100", (cyc - t_last_done) >= 100, 1'b1);
                act = 1'b1; act_cnt = 3; spi_busy = 1'b1;
            end else if (act) begin
                act_cnt--;
                if (act_cnt == 0) begin
                    act = 1'b0;
                    spi_done = 1'b1;
                    last_done_addr = cur.addr;
                    t_last_done = cyc;
                    if (cur.burst) begin
                        if (bq.size() == 0) begin
                            chk("burst_data_available", 1'b0, 1'b1);
                        end else begin
                            spi_bdata = bq.pop_front();
                            expq.push_back(parse(spi_bdata));
                        end
                    end else if (cur.rw) begin
                        spi_rdata = (idq.size() != 0) ? idq.pop_front() : 8'h32;
                    end
                    if (extra_busy == 0) spi_busy = 1'b0;
                    else post = extra_busy;
                end
            end
        end
    end

    // Output monitor: sample scoreboard, pulse width, init_done ordering
    always @(negedge clk) begin
        if (rst_n) begin
            if (data_valid) begin
                smp_t e, o;
                n_dv++;
                chk("dv_one_cycle", prev_dv, 1'b0);
                o.x = mag_x; o.y = mag_y; o.z = mag_z; o.rh = rhall; o.ovf = ovf; o.drdy = drdy;
                obsq.push_back(o);
                if (expq.size() == 0) begin
                    chk("unexpected_data_valid", 1'b1, 1'b0);
                end else begin
                    e = expq.pop_front();
                    chk("mag_x", $unsigned(mag_x), e.x);
                    chk("mag_y", $unsigned(mag_y), e.y);
                    chk("mag_z", $unsigned(mag_z), e.z);
                    chk("rhall", rhall, e.rh);
                    chk("ovf", ovf, e.ovf);
                    chk("drdy", drdy, e.drdy);
                end
            end
            if (init_done && !prev_init) begin
                n_init++;
                chk("init_after_opm_done", last_done_addr, 7'h4C);
            end
        end
        prev_dv = data_valid;
        prev_init = init_done;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dv_before, st_before;
        rst_n = 1'b0; enable = 1'b1;
        spi_rdata = 8'h00; spi_bdata = 64'h0;
        spi_busy = 1'b0; spi_done = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_spi_enable", spi_enable, 1'b0);
        chk("rst_spi_rw", spi_rw, 1'b1);
        chk("rst_spi_start", spi_start, 1'b0);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_data_valid", data_valid, 1'b0);
        chk("rst_mag_x", $unsigned(mag_x), 13'h0);

        opq.push_back(mk(1'b0, 1'b0, 7'h4B, 8'h01));
        opq.push_back(mk(1'b1, 1'b0, 7'h40, 8'h00));
        push_cfg();
        for (int i = 0; i < 3; i++) opq.push_back(mk(1'b1, 1'b1, 7'h42, 8'h00));
        idq.push_back(8'h32);
        bq.push_back(64'hF8_7F_08_80_FE_3F_01_40);
        bq.push_back(64'h00_80_12_34_56_78_9B_0C);
        rst_n = 1'b1;

        for (int i = 0; i < 3000 && n_dv < 2; i++) @(negedge clk);
        chk("two_samples_seen", n_dv >= 2, 1'b1);
        chk("init_done_high", init_done, 1'b1);
        if (obsq.size() >= 2) begin
            chk("t2_x_pos4095", {{51{obsq[0].x[12]}}, obsq[0].x}, 64'(4095));
            chk("t2_y_neg4095", {{51{obsq[0].y[12]}}, obsq[0].y}, 64'(-4095));
            chk("t2_z_pos8191", {{49{obsq[0].z[14]}}, obsq[0].z}, 64'(8191));
            chk("t2_drdy", obsq[0].drdy, 1'b1);
            chk("t2_ovf", obsq[0].ovf, 1'b0);
            chk("t3_ovf", obsq[1].ovf, 1'b1);
        end

        for (int i = 0; i < 500 && !(act && cur.burst && act_cnt >= 2); i++) @(negedge clk);
        chk("burst_in_flight", act && cur.burst, 1'b1);
        enable = 1'b0;
        dv_before = n_dv;
        @(negedge clk);
        chk("abort_spi_enable", spi_enable, 1'b0);
        chk("abort_init_done", init_done, 1'b0);
        st_before = n_starts;
        repeat (150) @(negedge clk);
        chk("abort_no_dv", n_dv, dv_before);
        chk("abort_no_start", n_starts, st_before);

        extra_busy = 5;
        opq.push_back(mk(1'b0, 1'b0, 7'h4B, 8'h01));
        opq.push_back(mk(1'b1, 1'b0, 7'h40, 8'h00));
        opq.push_back(mk(1'b0, 1'b0, 7'h4B, 8'h01));
        opq.push_back(mk(1'b1, 1'b0, 7'h40, 8'h00));
        push_cfg();
        opq.push_back(mk(1'b1, 1'b1, 7'h42, 8'h00));
        idq.push_back(8'h00);
        idq.push_back(8'h32);
        bq.push_back(64'h10_20_30_40_50_60_70_80);
        enable = 1'b1;

        for (int i = 0; i < 1000 && !id_err; i++) @(negedge clk);
        chk("id_err_set", id_err, 1'b1);
        chk("chip_id_bad", chip_id, 8'h00);
        for (int i = 0; i < 2000 && n_init < 2; i++) @(negedge clk);
        chk("retry_init_done", init_done, 1'b1);
        chk("retry_id_err_clear", id_err, 1'b0);
        chk("chip_id_good", chip_id, 8'h32);
        for (int i = 0; i < 1000 && n_dv < dv_before + 1; i++) @(negedge clk);
        chk("post_retry_sample", n_dv, dv_before + 1);
        if (obsq.size() >= 3) chk("drdy0_sample_updates", obsq[2].drdy, 1'b0);

        enable = 1'b0;
        repeat (5) @(negedge clk);
        chk("ops_all_consumed", opq.size(), 0);
        chk("bursts_all_consumed", bq.size(), 0);
        chk("samples_all_seen", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
